// File: rtl/bin_to_digit_scan.sv
// bin_to_digit_scan: 14-bit binary to 4-digit BCD (double-dabble)
// with a free-running one-hot digit scan onto a shared 4-bit bus.
module bin_to_digit_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  digit,
  output logic [3:0]  digit_en
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam logic [19:0] TC = 20'(REFRESH_DIV - 1);
  localparam logic [13:0] MAXV = 14'd9999;

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  iter;
  logic [15:0] disp;
  logic [15:0] disp_nxt;
  logic [19:0] rcnt;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic        tc;
  logic [3:0]  sel;
  logic        hi_zero;
  logic [3:0]  digit_nxt;

  // add-3 to every BCD nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[k*4 +: 4] >= 4'd5) begin
        bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
      end
    end
  end

  // conversion FSM; display register only changes in COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      ovf   <= 1'b0;
      bin   <= '0;
      bcd   <= '0;
      iter  <= '0;
      disp  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state <= CONV;
            busy  <= 1'b1;
            bcd   <= '0;
            iter  <= '0;
            if (value > MAXV) begin
              bin <= MAXV;
              ovf <= 1'b1;
            end else begin
              bin <= value;
              ovf <= 1'b0;
            end
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          iter <= iter + 4'd1;
          if (iter == 4'd13) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp  <= bcd;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // next-cycle view of display and scan index so the bus pair
  // always reflects the digits and position of the coming cycle
  always_comb begin
    disp_nxt = (state == COMMIT) ? bcd : disp;
    tc       = (rcnt == TC);
    idx_nxt  = tc ? idx + 2'd1 : idx;
    sel      = disp_nxt[idx_nxt*4 +: 4];
    hi_zero  = 1'b0;
    case (idx_nxt)
      2'd1: hi_zero = (disp_nxt[15:4] == 12'd0);
      2'd2: hi_zero = (disp_nxt[15:8] == 8'd0);
      2'd3: hi_zero = (disp_nxt[15:12] == 4'd0);
      default: hi_zero = 1'b0;
    endcase
    digit_nxt = (blank_lz && hi_zero) ? 4'hF : sel;
  end

  // free-running refresh counter and registered digit/enable pair
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      idx      <= '0;
      digit    <= 4'h0;
      digit_en <= 4'b0001;
    end else begin
      rcnt     <= tc ? 20'd0 : rcnt + 20'd1;
      idx      <= idx_nxt;
      digit    <= digit_nxt;
      digit_en <= 4'b0001 << idx_nxt;
    end
  end

endmodule

// File: tb/tb_bin_to_digit_scan.sv
// tb_bin_to_digit_scan: arithmetic reference model checked every
// cycle, plus directed literal expectations.
module tb_bin_to_digit_scan;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        ovf;
  logic [3:0]  digit;
  logic [3:0]  digit_en;

  int checks = 0;
  int errors = 0;

  bin_to_digit_scan #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .ovf      (ovf),
    .digit    (digit),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  int m_cyc = 0;
  int m_disp = 0;
  int m_pend = 0;
  int m_left = 0;
  bit m_ovf = 0;
  bit m_blz = 0;
  bit m_valid = 0;

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit(input int v, input int k,
                                           input bit blz);
    if (blz && k != 0 && v < pow10(k)) return 4'hF;
    return 4'((v / pow10(k)) % 10);
  endfunction

  // reference model: acceptance, 15-cycle latency, clamp, scan
  always @(posedge clk) begin
    m_valid = 1;
    m_blz = blank_lz;
    if (rst) begin
      m_cyc = 0;
      m_disp = 0;
      m_left = 0;
      m_ovf = 0;
      m_blz = 0;
    end else begin
      m_cyc++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pend;
      end else if (load) begin
        m_pend = (int'(value) > 9999) ? 9999 : int'(value);
        m_ovf = int'(value) > 9999;
        m_left = 15;
      end
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    int k;
    logic [3:0] ed;
    logic [3:0] ee;
    #2;
    if (m_valid) begin
      k = (m_cyc / RD) % 4;
      ee = 4'b0001 << k;
      ed = exp_digit(m_disp, k, m_blz);
      checks++;
      if (busy !== (m_left > 0) || ovf !== m_ovf ||
          digit_en !== ee || digit !== ed) begin
        errors++;
        $display("FAIL model t=%0t busy=%b/%b ovf=%b/%b en=%b/%b dig=%h/%h",
                 $time, busy, m_left > 0, ovf, m_ovf, digit_en, ee,
                 digit, ed);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_en(input logic [3:0] e);
    int n = 0;
    while (digit_en !== e && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (digit_en !== e) begin
      errors++;
      checks++;
      $display("FAIL wait_en got=%b exp=%b", digit_en, e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lit("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    value = 14'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic frame(input string name, input int d0, input int d1,
                       input int d2, input int d3);
    wait_en(4'b0001); lit({name, "_d0"}, int'(digit), d0);
    wait_en(4'b0010); lit({name, "_d1"}, int'(digit), d1);
    wait_en(4'b0100); lit({name, "_d2"}, int'(digit), d2);
    wait_en(4'b1000); lit({name, "_d3"}, int'(digit), d3);
  endtask

  initial begin
    int bc;
    rst = 1'b1;
    value = '0;
    load = 1'b0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    lit("rst_busy", int'(busy), 0);
    lit("rst_en", int'(digit_en), 1);
    lit("rst_digit", int'(digit), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    frame("idle", 0, 0, 0, 0);

    @(negedge clk);
    value = 14'd1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    lit("busy_len", bc, 15);
    frame("v1234", 4, 3, 2, 1);

    blank_lz = 1'b1;
    do_load(7);
    wait_idle();
    frame("v7", 7, 15, 15, 15);
    do_load(0);
    wait_idle();
    frame("v0", 0, 15, 15, 15);

    blank_lz = 1'b0;
    do_load(12000);
    lit("ovf_set", int'(ovf), 1);
    wait_idle();
    frame("v12000", 9, 9, 9, 9);
    do_load(5);
    lit("ovf_clr", int'(ovf), 0);
    wait_idle();

    do_load(8000);
    repeat (3) @(negedge clk);
    value = 14'd42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    frame("v8000", 0, 0, 0, 8);

    do_load(9876);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lit("abort_busy", int'(busy), 0);
    lit("abort_en", int'(digit_en), 1);
    lit("abort_dig", int'(digit), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    frame("abort", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
